ysyx_25060173_idu: RTL

Instruction decode stage for the RV32I core, sitting between the fetch unit and the execute stage. It takes a fetched `{pc, inst}` over a valid/ready handshake and reads the register file. It produces the one-hot 26-bit `alu_op` and both ALU operands, plus memory, branch and writeback control. All outputs go into a single registered pipeline slot with backpressure and flush.

---
 rtl/ysyx_25060173_pkg.sv | 77 +++++++
 rtl/ysyx_25060173_imm_gen.sv | 31 +++
 rtl/ysyx_25060173_idu.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25060173_pkg.sv
// Shared RV32I decode constants: opcodes, one-hot ALU operation indices and
// the decoded-instruction record carried by the decode output slot.
package ysyx_25060173_pkg;

    localparam int ALU_OP_W = 26;

    // One-hot ALU operation bit positions
    localparam int ALU_ADDI  = 0;
    localparam int ALU_AUIPC = 1;
    localparam int ALU_ADD   = 2;
    localparam int ALU_SUB   = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_BNE   = 5;
    localparam int ALU_BGE   = 6;
    localparam int ALU_BGEU  = 7;
    localparam int ALU_BLT   = 8;
    localparam int ALU_BLTU  = 9;
    localparam int ALU_BEQ   = 10;
    localparam int ALU_SLTIU = 11;
    localparam int ALU_SLLI  = 12;
    localparam int ALU_SLTU  = 13;
    localparam int ALU_XOR   = 14;
    localparam int ALU_OR    = 15;
    localparam int ALU_SLT   = 16;
    localparam int ALU_SRA   = 17;
    localparam int ALU_SRL   = 18;
    localparam int ALU_SLL   = 19;
    localparam int ALU_ANDI  = 20;
    localparam int ALU_SRLI  = 21;
    localparam int ALU_SRAI  = 22;
    localparam int ALU_XORI  = 23;
    localparam int ALU_ORI   = 24;
    localparam int ALU_SLTI  = 25;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0]  F7_BASE     = 7'h00;
    localparam logic [6:0]  F7_ALT      = 7'h20;
    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic [31:0]         pc;
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic [31:0]         rs2_data;
        logic [31:0]         imm;
        logic [4:0]          rd;
        logic                rf_we;
        logic                mem_re;
        logic                mem_we;
        logic [2:0]          mem_f3;
        logic                br;
        logic                br_inv;
        logic                jal;
        logic                jalr;
        logic                ebreak;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/ysyx_25060173_imm_gen.sv
// RV32I immediate extraction: chooses the I/S/B/U/J layout from the opcode
// and sign-extends from inst[31]. Formats without an immediate yield zero.
module ysyx_25060173_imm_gen
    import ysyx_25060173_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o
);

    // Immediate layout is a pure function of the opcode
    always_comb begin
        imm_o = '0;
        case (inst_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            OPC_STORE:
                imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {inst_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25060173_idu.sv
// RV32I decode stage. Decoding is purely combinational from the fetched word
// and register-file read data; the result lands in a single output slot that
// supports backpressure, same-cycle drain+refill, flush and reset.
module ysyx_25060173_idu
    import ysyx_25060173_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_inst,
    input  logic                flush,
    output logic [4:0]          rf_raddr1,
    output logic [4:0]          rf_raddr2,
    input  logic [31:0]         rf_rdata1,
    input  logic [31:0]         rf_rdata2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [31:0]         out_alu_src1,
    output logic [31:0]         out_alu_src2,
    output logic [31:0]         out_rs2_data,
    output logic [31:0]         out_imm,
    output logic [4:0]          out_rd,
    output logic                out_rf_we,
    output logic                out_mem_re,
    output logic                out_mem_we,
    output logic [2:0]          out_mem_f3,
    output logic                out_br,
    output logic                out_br_inv,
    output logic                out_jal,
    output logic                out_jalr,
    output logic                out_ebreak,
    output logic                out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        legal;
    logic        wb;
    logic        accept;
    dec_t        dec;
    dec_t        slot_d, slot_q;
    slot_state_e state_d, state_q;

    assign opcode    = in_inst[6:0];
    assign funct3    = in_inst[14:12];
    assign funct7    = in_inst[31:25];
    assign rd        = in_inst[11:7];
    assign rf_raddr1 = in_inst[19:15];
    assign rf_raddr2 = in_inst[24:20];

    ysyx_25060173_imm_gen u_imm_gen (
        .inst_i (in_inst),
        .imm_o  (imm)
    );

    // Decode the incoming word into the slot record; illegal encodings squash all side effects
    always_comb begin
        dec          = '0;
        legal        = 1'b1;
        wb           = 1'b0;
        dec.pc       = in_pc;
        dec.imm      = imm;
        dec.rd       = rd;
        dec.rs2_data = rf_rdata2;
        case (opcode)
            OPC_OP_IMM: begin
                dec.src1 = rf_rdata1;
                dec.src2 = imm;
                wb       = 1'b1;
                case (funct3)
                    3'd0: dec.alu_op[ALU_ADDI]  = 1'b1;
                    3'd1: begin
                        dec.alu_op[ALU_SLLI] = 1'b1;
                        legal = (funct7 == F7_BASE);
                    end
                    3'd2: dec.alu_op[ALU_SLTI]  = 1'b1;
                    3'd3: dec.alu_op[ALU_SLTIU] = 1'b1;
                    3'd4: dec.alu_op[ALU_XORI]  = 1'b1;
                    3'd5: begin
                        if (funct7 == F7_ALT) dec.alu_op[ALU_SRAI] = 1'b1;
                        else                  dec.alu_op[ALU_SRLI] = 1'b1;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'd6: dec.alu_op[ALU_ORI]   = 1'b1;
                    default: dec.alu_op[ALU_ANDI] = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec.src1 = rf_rdata1;
                dec.src2 = rf_rdata2;
                wb       = 1'b1;
                // Only sub and sra use the alternate funct7 encoding
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
                case (funct3)
                    3'd0: begin
                        if (funct7[5]) dec.alu_op[ALU_SUB] = 1'b1;
                        else           dec.alu_op[ALU_ADD] = 1'b1;
                    end
                    3'd1: dec.alu_op[ALU_SLL]  = 1'b1;
                    3'd2: dec.alu_op[ALU_SLT]  = 1'b1;
                    3'd3: dec.alu_op[ALU_SLTU] = 1'b1;
                    3'd4: dec.alu_op[ALU_XOR]  = 1'b1;
                    3'd5: begin
                        if (funct7[5]) dec.alu_op[ALU_SRA] = 1'b1;
                        else           dec.alu_op[ALU_SRL] = 1'b1;
                    end
                    3'd6: dec.alu_op[ALU_OR]   = 1'b1;
                    default: dec.alu_op[ALU_AND] = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.alu_op[ALU_ADDI] = 1'b1;
                dec.src2 = imm;
                wb       = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op[ALU_AUIPC] = 1'b1;
                dec.src1 = in_pc;
                dec.src2 = imm;
                wb       = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link value pc+4; the target uses out_imm
                dec.alu_op[ALU_ADD] = 1'b1;
                dec.src1 = in_pc;
                dec.src2 = 32'd4;
                dec.jal  = (opcode == OPC_JAL);
                dec.jalr = (opcode == OPC_JALR);
                wb       = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_op[ALU_ADDI] = 1'b1;
                dec.src1   = rf_rdata1;
                dec.src2   = imm;
                dec.mem_re = 1'b1;
                dec.mem_f3 = funct3;
                wb         = 1'b1;
                legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end
            OPC_STORE: begin
                dec.alu_op[ALU_ADDI] = 1'b1;
                dec.src1   = rf_rdata1;
                dec.src2   = imm;
                dec.mem_we = 1'b1;
                dec.mem_f3 = funct3;
                legal = (funct3 <= 3'd2);
            end
            OPC_BRANCH: begin
                dec.src1 = rf_rdata1;
                dec.src2 = rf_rdata2;
                dec.br   = 1'b1;
                case (funct3)
                    3'd0: dec.alu_op[ALU_BEQ]  = 1'b1;
                    3'd1: begin dec.alu_op[ALU_BNE]  = 1'b1; dec.br_inv = 1'b1; end
                    3'd4: dec.alu_op[ALU_BLT]  = 1'b1;
                    3'd5: begin dec.alu_op[ALU_BGE]  = 1'b1; dec.br_inv = 1'b1; end
                    3'd6: dec.alu_op[ALU_BLTU] = 1'b1;
                    3'd7: begin dec.alu_op[ALU_BGEU] = 1'b1; dec.br_inv = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_MISC_MEM: begin
                dec.alu_op[ALU_ADDI] = 1'b1;
            end
            OPC_SYSTEM: begin
                if (in_inst == EBREAK_INST) dec.ebreak = 1'b1;
                else                        legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.illegal = 1'b1;
            dec.alu_op  = '0;
            dec.mem_re  = 1'b0;
            dec.mem_we  = 1'b0;
            dec.br      = 1'b0;
            dec.br_inv  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
            wb          = 1'b0;
        end
        dec.rf_we = wb && (rd != 5'd0);
    end

    assign in_ready = (state_q == SLOT_EMPTY) | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // Slot next state: flush beats accept, accept beats drain
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (flush) begin
            state_d = SLOT_EMPTY;
        end else if (accept) begin
            state_d = SLOT_FULL;
            slot_d  = dec;
        end else if (out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Output slot register; reset clears payload too so outputs read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    assign out_valid    = (state_q == SLOT_FULL);
    assign out_pc       = slot_q.pc;
    assign out_alu_op   = slot_q.alu_op;
    assign out_alu_src1 = slot_q.src1;
    assign out_alu_src2 = slot_q.src2;
    assign out_rs2_data = slot_q.rs2_data;
    assign out_imm      = slot_q.imm;
    assign out_rd       = slot_q.rd;
    assign out_rf_we    = slot_q.rf_we;
    assign out_mem_re   = slot_q.mem_re;
    assign out_mem_we   = slot_q.mem_we;
    assign out_mem_f3   = slot_q.mem_f3;
    assign out_br       = slot_q.br;
    assign out_br_inv   = slot_q.br_inv;
    assign out_jal      = slot_q.jal;
    assign out_jalr     = slot_q.jalr;
    assign out_ebreak   = slot_q.ebreak;
    assign out_illegal  = slot_q.illegal;

endmodule
